alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one ALU between `NUM_REQ` requesters. Arbitration is round-robin, and each requester gets a valid/ready command port. The block issues one operation at a time to the ALU and waits for the ALU's `ready` pulse. It then returns the result, carry and requester ID on a single response port. It sits between the testbench- or core-side command sources and the ALU datapath (32-bit operands, 3-bit op code, carry out).

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; valid range 2..8.
- `TIMEOUT_CYCLES`, 16: watchdog limit in cycles. Used only with `ALU_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `nrst` in 1: reset. Asynchronous assert, active-low.
- `req_valid` in NUM_REQ: per-requester command valid.
- `req_ready` out NUM_REQ: per-requester accept; one-hot or zero.
- `req_a` in NUM_REQ*32: packed operand A, requester i at [32i+31:32i].
- `req_b` in NUM_REQ*32: packed operand B.
- `req_op` in NUM_REQ*3: packed op codes.
- `alu_a` out 32: operand A to the ALU.
- `alu_b` out 32: operand B to the ALU.
- `alu_op_code` out 3: op code to the ALU.
- `alu_start` out 1: one-cycle launch pulse.
- `alu_ready` in 1: one-cycle ALU done pulse.
- `alu_out` in 32: ALU result, valid with `alu_ready`.
- `alu_carry` in 1: ALU carry, valid with `alu_ready`.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accepted by the consumer.
- `rsp_data` out 32: captured result.
- `rsp_carry` out 1: captured carry.
- `rsp_id` out $clog2(NUM_REQ): ID of the granted requester.
- `rsp_err` out 1: watchdog abort flag.

## Operation
- FSM states:
  - IDLE → ISSUE: when any `req_valid` is high.
  - ISSUE → WAIT: unconditional.
  - WAIT → RESP: on `alu_ready`.
  - RESP → IDLE: on `rsp_ready`.
- IDLE:
  - The picker selects the first asserted `req_valid` at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - `req_ready[g]` is high combinationally in that cycle only, which completes the handshake.
  - The grant latches A, B, op and ID into holding registers.
- ISSUE: `alu_start`=1 for exactly one cycle. `alu_a`, `alu_b` and `alu_op_code` are driven from the holding registers.
- WAIT:
  - Operands stay stable until `alu_ready`.
  - `alu_ready` is sampled only in WAIT; it is ignored in every other state.
- On `alu_ready`: capture `alu_out` into `rsp_data` and `alu_carry` into `rsp_carry`, with `rsp_err`=0.
- RESP:
  - `rsp_valid` is held high until `rsp_ready`.
  - Data is stable while `rsp_valid && !rsp_ready`.
- Leaving RESP: `rr_ptr` is set to (granted ID + 1) mod NUM_REQ.
- `req_ready` is 0 in every state except IDLE; a requester waits for the whole transaction.
- A requester that drops `req_valid` before its grant is not granted. It is a requester protocol violation, and the arbiter does not check it.
- Reset values:
  - State IDLE, `rr_ptr`=0.
  - `req_ready`=0, `alu_start`=0.
  - `alu_a`, `alu_b`, `alu_op_code` all 0.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_carry`=0, `rsp_id`=0, `rsp_err`=0.
- Reset mid-transaction: everything returns to reset values immediately. Any in-flight result is dropped, and a later `alu_ready` in IDLE is ignored.

## Timing
- Cycle 0: grant (IDLE, `req_valid[g]` & `req_ready[g]`).
- Cycle 1: `alu_start`=1 (ISSUE).
- `alu_ready` first seen at cycle k ≥ 2 → `rsp_valid` rises at cycle k+1.
- Minimum grant-to-response latency is 3 cycles.
- With `rsp_ready` tied high, the next grant is at k+2.
- Throughput is one operation per (ALU latency + 3) cycles; there is no overlap.

## Configuration
- Macro: `ALU_ARB_TIMEOUT_EN`.
- When defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches `TIMEOUT_CYCLES` with no `alu_ready`, the FSM goes to RESP with `rsp_err`=1, `rsp_data`=0, `rsp_carry`=0.
  - `alu_ready` in the same cycle as expiry wins, giving a normal response.
- When undefined:
  - No counter; WAIT is unbounded.
  - `rsp_err` is tied to 0 and `TIMEOUT_CYCLES` is unused.

## Structure
- Additions to `alu_pkg`:
  - `ALU_W`=32 and `ALU_OP_W`=3 constants.
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_e`.
- One sub-module, `alu_rr_picker`:
  - Combinational rotating-priority picker.
  - Inputs: request vector and `rr_ptr`.
  - Outputs: `grant_valid` and `grant_id`.
- The FSM, holding registers and watchdog stay in `alu_arbiter`.

## Test plan
- **Single request:**
  - Stimulus: `req_valid[1]`, A=5, B=3, op=0; ALU returns `alu_out`=8, carry=0 two cycles after start.
  - Required response: `req_ready[1]` at cycle 0, `alu_start` at 1, `rsp_valid` at 4 with `rsp_id`=1, `rsp_data`=8.
- **Round-robin:**
  - Stimulus: all four `req_valid` held high from reset.
  - Required response: grant order 0,1,2,3,0; no requester is granted twice before every other asserted requester is granted.
- **Response backpressure:**
  - Stimulus: `rsp_ready`=0 for 5 cycles.
  - Required response: `rsp_valid`, `rsp_data` and `rsp_id` stable; no new `req_ready`; `alu_start` stays 0.
- **Carry/wrap:**
  - Stimulus: A=0xFFFF_FFFF, B=1; ALU returns out=0, carry=1.
  - Required response: `rsp_data`=0, `rsp_carry`=1.
- **Reset mid-WAIT:**
  - Stimulus: `nrst` pulsed low in WAIT, then a late `alu_ready` arrives.
  - Required response: all outputs at reset values; the late pulse produces no response; the next grant goes to requester 0 first.
- **Watchdog (with `ALU_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16):**
  - Stimulus: ALU never asserts `alu_ready`.
  - Required response: `rsp_valid` with `rsp_err`=1 and `rsp_data`=0, 17 cycles after `alu_start`.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and FSM state encoding for the ALU arbiter slice.
package alu_pkg;

    localparam int ALU_W    = 32;
    localparam int ALU_OP_W = 3;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundles the requester command ports, ALU launch/return and response port.
// The arbiter uses the slave modport; the surrounding environment uses master.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4
) ();

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*ALU_W-1:0]    req_a;
    logic [NUM_REQ*ALU_W-1:0]    req_b;
    logic [NUM_REQ*ALU_OP_W-1:0] req_op;

    logic [ALU_W-1:0]            alu_a;
    logic [ALU_W-1:0]            alu_b;
    logic [ALU_OP_W-1:0]         alu_op_code;
    logic                        alu_start;
    logic                        alu_ready;
    logic [ALU_W-1:0]            alu_out;
    logic                        alu_carry;

    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [ALU_W-1:0]            rsp_data;
    logic                        rsp_carry;
    logic [ID_W-1:0]             rsp_id;
    logic                        rsp_err;

    modport slave (
        input  req_valid, req_a, req_b, req_op,
        input  alu_ready, alu_out, alu_carry,
        input  rsp_ready,
        output req_ready,
        output alu_a, alu_b, alu_op_code, alu_start,
        output rsp_valid, rsp_data, rsp_carry, rsp_id, rsp_err
    );

    modport master (
        output req_valid, req_a, req_b, req_op,
        output alu_ready, alu_out, alu_carry,
        output rsp_ready,
        input  req_ready,
        input  alu_a, alu_b, alu_op_code, alu_start,
        input  rsp_valid, rsp_data, rsp_carry, rsp_id, rsp_err
    );

endinterface

// File: rtl/alu_rr_picker.sv
// Combinational rotating-priority picker: first asserted request at or
// after rr_ptr, wrapping modulo NUM_REQ.
module alu_rr_picker #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id
);

    int idx;

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = 0;
        // Scan farthest-to-nearest so the closest match to rr_ptr lands last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU among NUM_REQ requesters, one op in flight.
// Optional watchdog on the ALU wait enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic          clk,
    input logic          nrst,
    alu_arbiter_if.slave bus
);

    localparam int ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255)
    begin : g_bad_params
        $error("alu_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES 1..255");
    end

    arb_state_e          state, state_nxt;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     hold_id;
    logic [ALU_W-1:0]    hold_a, hold_b;
    logic [ALU_OP_W-1:0] hold_op;
    logic [ALU_W-1:0]    rsp_data_q;
    logic                rsp_carry_q;
    logic                grant_valid;
    logic [ID_W-1:0]     grant_id;
    logic                wd_expired;

    alu_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req         (bus.req_valid),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= ARB_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        case (state)
            ARB_IDLE: begin
                if (grant_valid) begin
                    bus.req_ready[grant_id] = 1'b1;
                    state_nxt               = ARB_ISSUE;
                end
            end
            ARB_ISSUE: state_nxt = ARB_WAIT;
            ARB_WAIT:  if (bus.alu_ready || wd_expired) state_nxt = ARB_RESP;
            ARB_RESP:  if (bus.rsp_ready) state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rr_ptr      <= '0;
            hold_id     <= '0;
            hold_a      <= '0;
            hold_b      <= '0;
            hold_op     <= '0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
        end else begin
            if (state == ARB_IDLE && grant_valid) begin
                hold_id <= grant_id;
                hold_a  <= bus.req_a[grant_id*ALU_W +: ALU_W];
                hold_b  <= bus.req_b[grant_id*ALU_W +: ALU_W];
                hold_op <= bus.req_op[grant_id*ALU_OP_W +: ALU_OP_W];
            end
            // A real ALU result takes priority over a same-cycle watchdog expiry.
            if (state == ARB_WAIT) begin
                if (bus.alu_ready) begin
                    rsp_data_q  <= bus.alu_out;
                    rsp_carry_q <= bus.alu_carry;
                end else if (wd_expired) begin
                    rsp_data_q  <= '0;
                    rsp_carry_q <= 1'b0;
                end
            end
            if (state == ARB_RESP && bus.rsp_ready)
                rr_ptr <= (hold_id == ID_W'(NUM_REQ - 1)) ? '0 : hold_id + 1'b1;
        end
    end

`ifdef ALU_ARB_TIMEOUT_EN
    logic [7:0] wd_cnt;
    logic       rsp_err_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)                  wd_cnt <= '0;
        else if (state == ARB_ISSUE) wd_cnt <= '0;
        else if (state == ARB_WAIT)  wd_cnt <= wd_cnt + 8'd1;
    end

    // wd_cnt counts completed WAIT cycles, so the current one is the last.
    assign wd_expired = (state == ARB_WAIT) && (wd_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            rsp_err_q <= 1'b0;
        else if (state == ARB_WAIT && (bus.alu_ready || wd_expired))
            rsp_err_q <= !bus.alu_ready;
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign wd_expired  = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.alu_a       = hold_a;
    assign bus.alu_b       = hold_b;
    assign bus.alu_op_code = hold_op;
    assign bus.alu_start   = (state == ARB_ISSUE);
    assign bus.rsp_valid   = (state == ARB_RESP);
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_carry   = rsp_carry_q;
    assign bus.rsp_id      = hold_id;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter: single op, pointer wrap, backpressure,
// carry, reset mid-WAIT, round-robin order and (optionally) the watchdog.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic nrst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   waited;
    logic [31:0] rr_a [N];
    logic [31:0] rr_b [N];

    always #5 clk = ~clk;

    alu_arbiter_if #(.NUM_REQ(N)) bus ();

    alu_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
        bus.req_op[i*3 +: 3]  = op;
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        while (bus.req_ready == '0 && n < 12) begin
            tick(); #1;
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "tb_alu_arbiter timeout");
    end

    initial begin
        nrst          = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.alu_ready = 1'b0;
        bus.alu_out   = '0;
        bus.alu_carry = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (2) tick();
        #1;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_alu_start", bus.alu_start, 0);
        check("rst_alu_a", bus.alu_a, 0);
        check("rst_alu_b", bus.alu_b, 0);
        check("rst_alu_op", bus.alu_op_code, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rsp_carry", bus.rsp_carry, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        nrst = 1'b1;

        // Single request from requester 1: 5 + 3, ALU answers 2 cycles after start.
        tick();
        set_req(1, 32'd5, 32'd3, 3'd0);
        bus.req_valid = 4'b0010;
        #1;
        check("t1_grant", bus.req_ready, 4'b0010);
        tick(); bus.req_valid = '0; #1;
        check("t1_start", bus.alu_start, 1);
        check("t1_alu_a", bus.alu_a, 5);
        check("t1_alu_b", bus.alu_b, 3);
        check("t1_alu_op", bus.alu_op_code, 0);
        check("t1_no_ready", bus.req_ready, 0);
        tick(); #1;
        check("t1_start_pulse", bus.alu_start, 0);
        check("t1_hold_a", bus.alu_a, 5);
        tick();
        bus.alu_ready = 1'b1; bus.alu_out = 32'd8; bus.alu_carry = 1'b0;
        #1;
        check("t1_rsp_early", bus.rsp_valid, 0);
        tick(); bus.alu_ready = 1'b0; #1;
        check("t1_rsp_valid", bus.rsp_valid, 1);
        check("t1_rsp_id", bus.rsp_id, 1);
        check("t1_rsp_data", bus.rsp_data, 8);
        check("t1_rsp_carry", bus.rsp_carry, 0);
        check("t1_rsp_err", bus.rsp_err, 0);

        // Pointer now 2: requesters 0 and 2 both valid, 2 must win. Carry/wrap op.
        tick();
        bus.rsp_ready = 1'b0;
        set_req(0, 32'h11, 32'h22, 3'd2);
        set_req(2, 32'hFFFF_FFFF, 32'd1, 3'd1);
        bus.req_valid = 4'b0101;
        #1;
        check("t2_grant", bus.req_ready, 4'b0100);
        tick(); bus.req_valid = 4'b0001; #1;
        check("t2_start", bus.alu_start, 1);
        check("t2_alu_a", bus.alu_a, 32'hFFFF_FFFF);
        check("t2_alu_b", bus.alu_b, 1);
        check("t2_alu_op", bus.alu_op_code, 1);
        tick();
        bus.alu_ready = 1'b1; bus.alu_out = 32'd0; bus.alu_carry = 1'b1;
        #1;
        tick(); bus.alu_ready = 1'b0; #1;
        check("t2_rsp_valid", bus.rsp_valid, 1);
        check("t2_rsp_data", bus.rsp_data, 0);
        check("t2_rsp_carry", bus.rsp_carry, 1);
        check("t2_rsp_id", bus.rsp_id, 2);

        // Backpressure for 5 cycles, with a stray alu_ready that must be ignored.
        for (int c = 0; c < 5; c++) begin
            tick();
            bus.alu_ready = (c == 2);
            bus.alu_out   = 32'hBAD;
            bus.alu_carry = 1'b0;
            #1;
            check("bp_rsp_valid", bus.rsp_valid, 1);
            check("bp_rsp_data", bus.rsp_data, 0);
            check("bp_rsp_carry", bus.rsp_carry, 1);
            check("bp_rsp_id", bus.rsp_id, 2);
            check("bp_req_ready", bus.req_ready, 0);
            check("bp_alu_start", bus.alu_start, 0);
        end
        bus.alu_ready = 1'b0;
        bus.rsp_ready = 1'b1;

        // Pointer moves to 3; only requester 0 is valid, so the grant wraps to 0.
        tick(); #1;
        check("t3_wrap_grant", bus.req_ready, 4'b0001);
        check("t3_rsp_done", bus.rsp_valid, 0);
        tick(); bus.req_valid = '0; #1;
        check("t3_alu_a", bus.alu_a, 32'h11);

        // Reset while in WAIT, then a late alu_ready in IDLE.
        tick(); #1;
        nrst = 1'b0;
        #1;
        check("rw_rsp_valid", bus.rsp_valid, 0);
        check("rw_alu_start", bus.alu_start, 0);
        check("rw_alu_a", bus.alu_a, 0);
        check("rw_alu_b", bus.alu_b, 0);
        check("rw_alu_op", bus.alu_op_code, 0);
        check("rw_rsp_carry", bus.rsp_carry, 0);
        check("rw_req_ready", bus.req_ready, 0);
        tick();
        nrst = 1'b1;
        bus.alu_ready = 1'b1; bus.alu_out = 32'hDEAD_BEEF; bus.alu_carry = 1'b1;
        #1;
        tick(); bus.alu_ready = 1'b0; #1;
        check("late_rsp_valid", bus.rsp_valid, 0);
        check("late_alu_start", bus.alu_start, 0);
        tick(); #1;
        check("late_rsp_valid2", bus.rsp_valid, 0);
        check("late_rsp_data", bus.rsp_data, 0);

        // All four requesters held valid: expect grants 0,1,2,3,0 back to back.
        for (int i = 0; i < N; i++) begin
            rr_a[i] = 32'h100 * (i + 1);
            rr_b[i] = i + 1;
            set_req(i, rr_a[i], rr_b[i], 3'(i));
        end
        bus.req_valid = 4'b1111;
        #1;
        for (int i = 0; i < 5; i++) begin
            wait_grant(waited);
            check("rr_grant", bus.req_ready, 1 << (i % N));
            if (i > 0) check("rr_back2back", waited, 0);
            tick(); #1;
            check("rr_start", bus.alu_start, 1);
            check("rr_alu_a", bus.alu_a, rr_a[i % N]);
            tick();
            bus.alu_ready = 1'b1;
            bus.alu_out   = rr_a[i % N] + rr_b[i % N];
            bus.alu_carry = 1'b0;
            #1;
            tick();
            bus.alu_ready = 1'b0;
            if (i == 4) bus.req_valid = '0;
            #1;
            check("rr_rsp_valid", bus.rsp_valid, 1);
            check("rr_rsp_id", bus.rsp_id, i % N);
            check("rr_rsp_data", bus.rsp_data, rr_a[i % N] + rr_b[i % N]);
            tick(); #1;
        end
        check("rr_idle_ready", bus.req_ready, 0);

`ifdef ALU_ARB_TIMEOUT_EN
        // ALU never answers: error response 17 cycles after alu_start.
        tick();
        set_req(1, 32'hAAAA, 32'h5555, 3'd3);
        bus.req_valid = 4'b0010;
        #1;
        check("wd_grant", bus.req_ready, 4'b0010);
        tick(); bus.req_valid = '0; #1;
        check("wd_start", bus.alu_start, 1);
        repeat (16) tick();
        #1;
        check("wd_not_yet", bus.rsp_valid, 0);
        tick(); #1;
        check("wd_rsp_valid", bus.rsp_valid, 1);
        check("wd_rsp_err", bus.rsp_err, 1);
        check("wd_rsp_data", bus.rsp_data, 0);
        check("wd_rsp_carry", bus.rsp_carry, 0);
        check("wd_rsp_id", bus.rsp_id, 1);
`endif

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
